// File: rtl/mem_map_pkg.sv
// System memory map constants and arbiter owner encoding
// shared by the memory arbiter and its helpers.
package mem_map_pkg;

    localparam logic [15:0] VID_BASE = 16'hB800;
    localparam int          VID_SIZE = 2048;
    localparam logic [15:0] ROM_BASE = 16'hC000;
    localparam logic [15:0] RAM_TOP  = 16'h7FFF;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_VID
    } owner_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive video grants while the CPU waits and
// raises cpu_force once the run reaches MAX_VID_RUN.
module arb_starve_cnt #(
    parameter int MAX_VID_RUN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cpu_req,
    input  logic cpu_gnt,
    input  logic vid_gnt,
    output logic cpu_force
);

    logic [3:0] r_cnt;

    assign cpu_force = cpu_req && (r_cnt == 4'(MAX_VID_RUN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!cpu_req || cpu_gnt) begin
            r_cnt <= '0;
        end else if (vid_gnt && r_cnt != 4'(MAX_VID_RUN)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// CPU / text-video arbiter for the single-port 64Kx8 memory.
// Optional BIOS write protection is enabled with ROM_WP_EN.
module mem_arbiter
    import mem_map_pkg::*;
#(
    parameter logic [15:0] VID_BASE    = mem_map_pkg::VID_BASE,
    parameter int          MAX_VID_RUN = 4
`ifdef ROM_WP_EN
    ,
    parameter logic [15:0] ROM_BASE    = mem_map_pkg::ROM_BASE
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [7:0]  cpu_rdata,
    input  logic        vid_req,
    input  logic [10:0] vid_addr,
    output logic        vid_gnt,
    output logic        vid_rvalid,
    output logic [7:0]  vid_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        wp_err
);

    logic        w_force;
    logic        w_vid_gnt;
    logic        w_cpu_gnt;
    logic        w_rom_wr;
    logic [15:0] w_vid_addr;
    logic [15:0] r_addr;
    owner_t      r_owner;
    logic [7:0]  r_cpu_rdata;
    logic [7:0]  r_vid_rdata;
    logic        r_wp_err;

    arb_starve_cnt #(
        .MAX_VID_RUN (MAX_VID_RUN)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_gnt   (w_cpu_gnt),
        .vid_gnt   (w_vid_gnt),
        .cpu_force (w_force)
    );

    assign w_vid_gnt  = vid_req && !w_force;
    assign w_cpu_gnt  = cpu_req && !w_vid_gnt;
    assign vid_gnt    = w_vid_gnt;
    assign cpu_gnt    = w_cpu_gnt;
    assign w_vid_addr = VID_BASE + {5'b0, vid_addr};

    assign mem_addr  = w_vid_gnt ? w_vid_addr :
                       w_cpu_gnt ? cpu_addr   : r_addr;
    assign mem_wdata = cpu_wdata;

`ifdef ROM_WP_EN
    // Blocked ROM writes still consume their grant slot
    assign w_rom_wr = w_cpu_gnt && cpu_we && (cpu_addr >= ROM_BASE);
    assign mem_we   = w_cpu_gnt && cpu_we && !w_rom_wr;
`else
    assign w_rom_wr = 1'b0;
    assign mem_we   = w_cpu_gnt && cpu_we;
`endif

    assign cpu_rvalid = (r_owner == OWN_CPU);
    assign vid_rvalid = (r_owner == OWN_VID);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : r_cpu_rdata;
    assign vid_rdata  = vid_rvalid ? mem_rdata : r_vid_rdata;
    assign wp_err     = r_wp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_owner     <= OWN_NONE;
            r_cpu_rdata <= '0;
            r_vid_rdata <= '0;
            r_wp_err    <= 1'b0;
        end else begin
            r_addr   <= mem_addr;
            r_wp_err <= w_rom_wr;
            if (w_vid_gnt) begin
                r_owner <= OWN_VID;
            end else if (w_cpu_gnt && !cpu_we) begin
                r_owner <= OWN_CPU;
            end else begin
                r_owner <= OWN_NONE;
            end
            if (cpu_rvalid) begin
                r_cpu_rdata <= mem_rdata;
            end
            if (vid_rvalid) begin
                r_vid_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes
// expected read data, a monitor pops it on each rvalid.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        vid_req;
    logic [10:0] vid_addr;
    logic        vid_gnt;
    logic        vid_rvalid;
    logic [7:0]  vid_rdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        wp_err;

    logic [7:0]  mem [0:65535];
    logic [7:0]  cq[$];
    logic [7:0]  vq[$];
    int          n_cmp;
    int          n_bad;

    mem_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_we     (cpu_we),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_gnt    (vid_gnt),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .wp_err     (wp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory preloaded with addr[7:0] ^ addr[15:8]
    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a] <= 8'(a) ^ 8'(a >> 8);
        end
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    function automatic logic [7:0] vexp(input logic [10:0] a);
        logic [15:0] full;
        full = 16'hB800 + {5'b0, a};
        return full[7:0] ^ full[15:8];
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cpu_rvalid) begin
            if (cq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cpu_rvalid_unexpected: got 1 expected 0");
            end else begin
                chk("cpu_rdata", {8'h0, cpu_rdata}, {8'h0, cq.pop_front()});
            end
        end
        if (vid_rvalid) begin
            if (vq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL vid_rvalid_unexpected: got 1 expected 0");
            end else begin
                chk("vid_rdata", {8'h0, vid_rdata}, {8'h0, vq.pop_front()});
            end
        end
    end

    // One arbitration cycle; CPU always reads 0x0100 (holds 8'h5A)
    task automatic step(input logic creq, input logic vreq,
                        input byte e);
        logic vg;
        cpu_req  = creq;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0100;
        vid_req  = vreq;
        @(negedge clk);
        chk($sformatf("vid_gnt_%c", e), {15'h0, vid_gnt},
            {15'h0, e == "V"});
        chk($sformatf("cpu_gnt_%c", e), {15'h0, cpu_gnt},
            {15'h0, e == "C"});
        vg = vid_gnt;
        if (vid_gnt) vq.push_back(vexp(vid_addr));
        if (cpu_gnt) cq.push_back(8'h5A);
        @(posedge clk);
        #1;
        if (vg) vid_addr = vid_addr + 11'd1;
    endtask

    initial begin
        string pat;
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        cpu_we    = 1'b0;
        cpu_wdata = '0;
        vid_req   = 1'b0;
        vid_addr  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_rvalid", {15'h0, cpu_rvalid}, 16'h0);
        chk("rst_vid_rvalid", {15'h0, vid_rvalid}, 16'h0);
        chk("rst_mem_we", {15'h0, mem_we}, 16'h0);
        chk("rst_wp_err", {15'h0, wp_err}, 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // CPU write then read; grant possible right after reset
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'h0100;
        cpu_wdata = 8'h5A;
        @(negedge clk);
        chk("wr_cpu_gnt", {15'h0, cpu_gnt}, 16'h1);
        chk("wr_mem_we", {15'h0, mem_we}, 16'h1);
        chk("wr_mem_addr", mem_addr, 16'h0100);
        @(posedge clk);
        #1;
        cpu_we = 1'b0;
        @(negedge clk);
        chk("rd_cpu_gnt", {15'h0, cpu_gnt}, 16'h1);
        chk("rd_mem_we", {15'h0, mem_we}, 16'h0);
        cq.push_back(8'h5A);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;

        // Video only
        vid_req  = 1'b1;
        vid_addr = 11'h010;
        @(negedge clk);
        chk("v_gnt", {15'h0, vid_gnt}, 16'h1);
        chk("v_mem_addr", mem_addr, 16'hB810);
        vq.push_back(8'hA8);
        @(posedge clk);
        #1;
        vid_req = 1'b0;
        @(negedge clk);
        chk("idle_addr_hold", mem_addr, 16'hB810);
        chk("idle_mem_we", {15'h0, mem_we}, 16'h0);
        @(posedge clk);
        #1;

        // Both continuous: 4 video then 1 CPU, repeating
        vid_addr = 11'h020;
        pat = "VVVVCVVVVC";
        for (int i = 0; i < pat.len(); i++) step(1'b1, 1'b1, pat[i]);

        // CPU drops mid-run: counter restarts from zero
        step(1'b1, 1'b1, "V");
        step(1'b1, 1'b1, "V");
        step(1'b0, 1'b1, "V");
        pat = "VVVVC";
        for (int i = 0; i < pat.len(); i++) step(1'b1, 1'b1, pat[i]);
        step(1'b1, 1'b0, "C");
        cpu_req = 1'b0;

        // Reset during an outstanding video read
        vid_req  = 1'b1;
        vid_addr = 11'h100;
        @(negedge clk);
        chk("mr_vid_gnt", {15'h0, vid_gnt}, 16'h1);
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        vid_req = 1'b0;
        @(negedge clk);
        chk("mr_vid_rvalid", {15'h0, vid_rvalid}, 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // CPU write to BIOS area
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'hE000;
        cpu_wdata = 8'hFF;
        @(negedge clk);
        chk("rom_cpu_gnt", {15'h0, cpu_gnt}, 16'h1);
`ifdef ROM_WP_EN
        chk("rom_mem_we", {15'h0, mem_we}, 16'h0);
`else
        chk("rom_mem_we", {15'h0, mem_we}, 16'h1);
`endif
        chk("rom_wp_pre", {15'h0, wp_err}, 16'h0);
        @(posedge clk);
        #1;
        cpu_we = 1'b0;
        @(negedge clk);
`ifdef ROM_WP_EN
        chk("rom_wp_err", {15'h0, wp_err}, 16'h1);
        cq.push_back(8'hE0);
`else
        chk("rom_wp_err", {15'h0, wp_err}, 16'h0);
        cq.push_back(8'hFF);
`endif
        chk("rom_rd_gnt", {15'h0, cpu_gnt}, 16'h1);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rom_wp_end", {15'h0, wp_err}, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("cpu_q_empty", 16'(cq.size()), 16'h0);
        chk("vid_q_empty", 16'(vq.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
